pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the load-enable and flush (bubble) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC load.
- Detects load-use hazards and inserts LOAD_DELAY bubbles.
- Flushes wrong-path instructions on taken branch/jump; freezes the whole pipe while data memory is busy.
- Keeps saturating stall and flush counters for debug.

Parameters:
- LOAD_DELAY, 1, number of bubbles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_dest  in  5  destination register of the instruction in EX (ID/EX dest_out).
- ex_mem_read  in  1  EX instruction is a load (ID/EX MemRead_out).
- branch_taken  in  1  branch resolved taken in EX this cycle.
- goto  in  1  jump in EX this cycle (ID/EX goto_out).
- mem_busy  in  1  data memory not ready; the access in MEM must be held.
- pc_load  out  1  PC register load enable.
- if_id_load  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP instead of its input.
- id_ex_load  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads all-zero controls (bubble).
- ex_mem_load  out  1  EX/MEM load enable.
- mem_wb_load  out  1  MEM/WB load enable.
- stalled  out  1  high in any cycle where pc_load=0.
- stall_cnt  out  CNT_W  cycles with stalled=1, saturating.
- flush_cnt  out  CNT_W  redirect events (branch_taken|goto accepted), saturating.

Behaviour:
- Controls are combinational from the registered state and the current inputs. State, countdown and counters update on the rising clock edge.
- Reset (reset=0 at an edge): state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
- While reset=0, all load and flush outputs are 0 and stalled=0. Reset mid-stall aborts the stall with no residue.
- hazard = ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).
- redirect = branch_taken | goto.
- States: RUN, LOAD_STALL (4-bit cnt). Priority, highest first: mem_busy > redirect > hazard / LOAD_STALL > normal.
- Freeze (mem_busy=1, any state):
  - All load outputs 0, all flush outputs 0, stalled=1.
  - State and cnt hold. redirect and hazard are ignored this cycle; EX is frozen, so they are re-presented after release.
- Redirect (mem_busy=0, redirect=1):
  - pc_load=1, all loads=1, if_id_flush=1, id_ex_flush=1.
  - flush_cnt increments; next state RUN, cnt=0.
  - Aborts any LOAD_STALL in progress.
- RUN with hazard:
  - pc_load=0, if_id_load=0, id_ex_load=1, id_ex_flush=1, ex_mem_load=1, mem_wb_load=1, stalled=1.
  - If LOAD_DELAY=1, stay in RUN. Otherwise go to LOAD_STALL with cnt=LOAD_DELAY-1.
- LOAD_STALL:
  - Same outputs as the hazard case.
  - cnt decrements each non-frozen cycle; the cycle with cnt=1 returns to RUN.
- RUN with no event: all loads 1, flushes 0, stalled=0.
- Flush outputs only assert together with the matching load=1. A flush never overrides a freeze.
- Counters: stall_cnt increments when stalled=1. Both counters saturate at all-ones and do not wrap.
- ex_dest=0 never causes a hazard.
- Simultaneous hazard and redirect: redirect wins; no bubble and no stall count.

Test Plan:
- Reset: hold reset=0 for 2 cycles with redirect=1, mem_busy=1 -> all outputs 0, counters 0. First cycle after release with no events -> all loads 1.
- Load-use, LOAD_DELAY=1: ex_mem_read=1, ex_dest=5, id_rs=5 for one cycle -> exactly 1 cycle of pc_load=0, id_ex_flush=1; stall_cnt=1.
- Load-use, LOAD_DELAY=3: ex_dest=7, id_rt=7, id_uses_rt=1 -> 3 consecutive bubble cycles, then RUN; stall_cnt=3. Same stimulus with id_uses_rt=0 -> no stall.
- Redirect aborts stall (LOAD_DELAY=3): branch_taken=1 in the 2nd bubble cycle -> that cycle pc_load=1, if_id_flush=id_ex_flush=1; next cycle RUN; flush_cnt=1, stall_cnt=1.
- Freeze: mem_busy=1 for 4 cycles during LOAD_STALL with cnt=2 -> all loads 0 for 4 cycles, cnt holds. After release, 2 more bubble cycles; stall_cnt advances by 6.
- Saturation (CNT_W=4): stall continuously for 20 cycles -> stall_cnt=15, holds. ex_dest=0 with ex_mem_read=1, id_rs=0 -> no stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, redirect and freeze sequencing for the 5-stage pipeline
//
// Purpose: drives the PC load and the load/flush controls of the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers. Inserts LOAD_DELAY bubbles per load-use
// hazard, squashes wrong-path work on a taken branch or jump, and freezes the
// whole pipe while data memory is busy. Keeps saturating debug counters.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   id_rs, id_rt, id_uses_rt     source registers of the instruction in ID
//   ex_dest, ex_mem_read         destination / load flag of the instruction in EX
//   branch_taken, goto           control-flow redirect resolved in EX
//   mem_busy                     data memory not ready, hold everything
//   pc_load, *_load, *_flush     pipeline register controls
//   stalled                      PC not advancing this cycle
//   stall_cnt, flush_cnt         saturating stall-cycle / redirect counters
module pipeline_ctrl #(
    parameter int LOAD_DELAY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             goto,
    input  logic             mem_busy,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_flush,
    output logic             id_ex_load,
    output logic             id_ex_flush,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN = 1'b0, LOAD_STALL = 1'b1} state_t;

    // The hazard cycle itself is the first bubble, so the countdown covers the rest.
    localparam logic [3:0]       STALL_INIT = 4'(LOAD_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       hazard;
    logic       redirect;
    logic       redirect_taken;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = ex_mem_read && (ex_dest != 5'd0) &&
                    ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    assign redirect = branch_taken || goto;

    always_comb begin
        pc_load        = 1'b0;
        if_id_load     = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_load     = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_load    = 1'b0;
        mem_wb_load    = 1'b0;
        stalled        = 1'b0;
        redirect_taken = 1'b0;
        state_next     = state;
        cnt_next       = cnt;

        if (!reset) begin
            // Everything held low; state is cleared by the register process.
        end else if (mem_busy) begin
            // EX is frozen too, so redirect/hazard are seen again after release.
            stalled = 1'b1;
        end else if (redirect) begin
            pc_load        = 1'b1;
            if_id_load     = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_load     = 1'b1;
            id_ex_flush    = 1'b1;
            ex_mem_load    = 1'b1;
            mem_wb_load    = 1'b1;
            redirect_taken = 1'b1;
            state_next     = RUN;
            cnt_next       = 4'd0;
        end else if (state == LOAD_STALL || hazard) begin
            // Hold PC and IF/ID, push a bubble into EX, let the load drain.
            id_ex_load  = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            stalled     = 1'b1;
            if (state == LOAD_STALL) begin
                if (cnt <= 4'd1) begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end else if (LOAD_DELAY > 1) begin
                state_next = LOAD_STALL;
                cnt_next   = STALL_INIT;
            end
        end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stalled && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (redirect_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
